// File: rtl/imm_decode_if.sv
// imm_decode_if: fetch-to-execute bundle for the immediate decode stage.
// Ports: in_* (valid/ready instruction + PC from IF), out_* (valid/ready decoded entry to EX).
// slave = the decode stage itself, master = the IF/EX side driving/consuming it.
interface imm_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_type;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_type, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_type, out_illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RV32I ID-stage immediate decoder behind a 2-entry skid buffer.
// Ports: clk, rst_n (async active-low), flush (sync), bus (imm_decode_if.slave).
// Latency accept->out_valid is 1 cycle; in_ready is a flop, so EX ready never reaches IF combinationally.
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  imm_decode_if.slave  bus
);

  localparam logic [2:0] RTYPE = 3'd0;
  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] STYPE = 3'd2;
  localparam logic [2:0] BTYPE = 3'd3;
  localparam logic [2:0] UTYPE = 3'd4;
  localparam logic [2:0] JTYPE = 3'd5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            illegal;
  } entry_t;

  entry_t     mem [2];
  entry_t     dec;
  logic       head;
  logic       wr_idx;
  logic [1:0] state;
  logic [1:0] next_state;
  logic       ready_q;
  logic       accept;
  logic       pop;

  assign accept = bus.in_valid & ready_q;
  assign pop    = (state != ST_EMPTY) & bus.out_ready;

  // Decode straight from the incoming word so the entry is complete when written.
  always_comb begin
    logic [31:0] i;
    i           = bus.in_instr;
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.instr   = i;
    dec.typ     = RTYPE;
    dec.illegal = 1'b0;
    case (i[6:0])
      7'b0110111, 7'b0010111: begin
        dec.typ = UTYPE;
        dec.imm = {i[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.typ = JTYPE;
        dec.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011: begin
        dec.typ = ITYPE;
        dec.imm = {{21{i[31]}}, i[30:20]};
      end
      7'b0100011: begin
        dec.typ = STYPE;
        dec.imm = {{21{i[31]}}, i[30:25], i[11:7]};
      end
      7'b1100011: begin
        dec.typ = BTYPE;
        dec.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      end
      7'b0110011: begin
        dec.typ = RTYPE;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_EMPTY: if (accept) next_state = ST_ONE;
      ST_ONE: begin
        if (accept && !pop)      next_state = ST_FULL;
        else if (pop && !accept) next_state = ST_EMPTY;
      end
      ST_FULL:  if (pop) next_state = ST_ONE;
      default:  next_state = ST_EMPTY;
    endcase
    if (flush) next_state = ST_EMPTY;
  end

  // With one entry held, the new word goes behind the head. On accept+pop in ONE
  // the head pointer moves onto that slot, so the new word becomes head.
  assign wr_idx = (state == ST_ONE) ? ~head : head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b0;
      head    <= 1'b0;
      mem[0]  <= '0;
      mem[1]  <= '0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state != ST_FULL);
      if (pop) head <= ~head;
      // A word offered during flush is discarded, never written.
      if (accept && !flush) mem[wr_idx] <= dec;
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = (state != ST_EMPTY);
  assign bus.out_instr   = mem[head].instr;
  assign bus.out_pc      = mem[head].pc;
  assign bus.out_imm     = mem[head].imm;
  assign bus.out_type    = mem[head].typ;
  assign bus.out_illegal = mem[head].illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;
  logic clk;
  logic rst_n;
  logic flush;
  int   tests;
  int   fails;

  imm_decode_if bus();

  imm_decode_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model, written from the immediate bit layouts.
  function automatic exp_t model(logic [31:0] w, logic [31:0] pc);
    exp_t e;
    logic [31:0] sh;
    sh      = $unsigned($signed(w) >>> 20);
    e.pc    = pc;
    e.instr = w;
    e.imm   = 32'h0;
    e.typ   = 3'd0;
    e.ill   = 1'b0;
    case (w[6:0])
      7'h37, 7'h17: begin e.typ = 3'd4; e.imm = w & 32'hFFFFF000; end
      7'h6F: begin
        e.typ = 3'd5;
        e.imm = (w[31] ? 32'hFFF00000 : 32'h0) | (w & 32'h000FF000)
              | ({31'b0, w[20]} << 11) | ((w >> 20) & 32'h000007FE);
      end
      7'h67, 7'h03, 7'h13: begin e.typ = 3'd1; e.imm = sh; end
      7'h23: begin e.typ = 3'd2; e.imm = sh; e.imm[4:0] = w[11:7]; end
      7'h63: begin
        e.typ = 3'd3; e.imm = sh;
        e.imm[11] = w[7]; e.imm[4:1] = w[11:8]; e.imm[0] = 1'b0;
      end
      7'h33: e.typ = 3'd0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Sample handshake before the rising edge, update the scoreboard, advance one cycle.
  task automatic tick();
    logic acc;
    logic pp;
    exp_t e;
    acc = bus.in_valid && bus.in_ready && rst_n;
    pp  = bus.out_valid && bus.out_ready && rst_n;
    if (pp) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pop_instr", bus.out_instr, 32'hDEADBEEF);
      end else begin
        e = sb.pop_front();
        chk("pop_instr", bus.out_instr, e.instr);
        chk("pop_pc", bus.out_pc, e.pc);
        chk("pop_imm", bus.out_imm, e.imm);
        chk("pop_type", {29'b0, bus.out_type}, {29'b0, e.typ});
        chk("pop_illegal", {31'b0, bus.out_illegal}, {31'b0, e.ill});
      end
    end
    if (flush) sb.delete();
    else if (acc) sb.push_back(model(bus.in_instr, bus.in_pc));
    @(negedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] w, logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = w;
    bus.in_pc    = pc;
  endtask

  initial begin
    logic [31:0] s2_w [3];
    logic [31:0] s2_i [3];
    logic [2:0]  s2_t [3];
    logic        got;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    s2_w = '{32'h12345037, 32'hFFDFF06F, 32'hFE000CE3};
    s2_i = '{32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFF8};
    s2_t = '{3'd4, 3'd5, 3'd3};

    // Reset state
    #2;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_imm", bus.out_imm, 32'h0);
    chk("rst_out_type", {29'b0, bus.out_type}, 32'h0);
    chk("rst_out_illegal", {31'b0, bus.out_illegal}, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("rst_rel_in_ready_low", {31'b0, bus.in_ready}, 32'h0);
    tick();
    chk("rst_rel_in_ready_high", {31'b0, bus.in_ready}, 32'h1);

    // 1: addi x1,x0,-1
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("t1_out_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("t1_imm", bus.out_imm, 32'hFFFFFFFF);
    chk("t1_type", {29'b0, bus.out_type}, 32'h1);
    chk("t1_illegal", {31'b0, bus.out_illegal}, 32'h0);
    chk("t1_pc", bus.out_pc, 32'h100);
    tick();
    chk("t1_drained", {31'b0, bus.out_valid}, 32'h0);

    // 2: back-to-back U/J/B stream
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, s2_w[i], 32'h200 + 32'(4 * i));
      else       drive(1'b0, 32'h0, 32'h0);
      if (i > 0) begin
        chk("t2_out_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("t2_imm", bus.out_imm, s2_i[i-1]);
        chk("t2_type", {29'b0, bus.out_type}, {29'b0, s2_t[i-1]});
      end
      chk("t2_in_ready", {31'b0, bus.in_ready}, 32'h1);
      tick();
    end
    chk("t2_sb_empty", 32'(sb.size()), 32'h0);

    // 3: backpressure fills both entries, third word waits
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00500113, 32'h300);
    tick();
    chk("t3_ready_after_1", {31'b0, bus.in_ready}, 32'h1);
    drive(1'b1, 32'h00112223, 32'h304);
    tick();
    chk("t3_ready_full", {31'b0, bus.in_ready}, 32'h0);
    chk("t3_head_held", bus.out_instr, 32'h00500113);
    drive(1'b1, 32'h00C0006F, 32'h308);
    tick();
    chk("t3_still_full", {31'b0, bus.in_ready}, 32'h0);
    chk("t3_head_stable", bus.out_instr, 32'h00500113);
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (bus.in_ready) got = 1'b1;
      tick();
      if (got) drive(1'b0, 32'h0, 32'h0);
    end
    chk("t3_third_accepted", {31'b0, got}, 32'h1);
    for (int k = 0; k < 4; k++) tick();
    chk("t3_sb_empty", 32'(sb.size()), 32'h0);

    // 4: flush while FULL and while ONE, offered word dropped
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00A00513, 32'h400);
    tick();
    drive(1'b1, 32'h00B00593, 32'h404);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'hABCDE037, 32'h408);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("t4_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("t4_in_ready", {31'b0, bus.in_ready}, 32'h1);
    chk("t4_not_shown", {31'b0, bus.out_instr === 32'hABCDE037}, 32'h0);
    drive(1'b1, 32'h00C00613, 32'h40C);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h1234506F, 32'h410);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("t4b_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("t4b_in_ready", {31'b0, bus.in_ready}, 32'h1);
    chk("t4b_not_shown", {31'b0, bus.out_instr === 32'h1234506F}, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    chk("t4_stays_empty", {31'b0, bus.out_valid}, 32'h0);

    // 5: illegal opcode, then R-type add
    drive(1'b1, 32'h0000007F, 32'h500);
    tick();
    drive(1'b1, 32'h00B50533, 32'h504);
    chk("t5_bad_illegal", {31'b0, bus.out_illegal}, 32'h1);
    chk("t5_bad_imm", bus.out_imm, 32'h0);
    chk("t5_bad_type", {29'b0, bus.out_type}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("t5_add_illegal", {31'b0, bus.out_illegal}, 32'h0);
    chk("t5_add_imm", bus.out_imm, 32'h0);
    chk("t5_add_type", {29'b0, bus.out_type}, 32'h0);
    tick();

    // 6: async reset mid-stream while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0FF00093, 32'h600);
    tick();
    drive(1'b1, 32'h80000637, 32'h604);
    tick();
    drive(1'b1, 32'hFE0008E3, 32'h608);
    chk("t6_full", {31'b0, bus.in_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("t6_rst_in_ready", {31'b0, bus.in_ready}, 32'h0);
    chk("t6_rst_out_instr", bus.out_instr, 32'h0);
    chk("t6_rst_out_imm", bus.out_imm, 32'h0);
    sb.delete();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("t6_rel_in_ready_low", {31'b0, bus.in_ready}, 32'h0);
    tick();
    chk("t6_rel_in_ready", {31'b0, bus.in_ready}, 32'h1);
    chk("t6_rel_out_valid", {31'b0, bus.out_valid}, 32'h0);
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0040A103, 32'h700);
    tick();
    drive(1'b1, 32'h00208463, 32'h704);
    chk("t6_resume_instr", bus.out_instr, 32'h0040A103);
    chk("t6_resume_imm", bus.out_imm, 32'h00000004);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("t6_resume_b_imm", bus.out_imm, 32'h00000008);
    for (int k = 0; k < 3; k++) tick();
    chk("t6_sb_empty", 32'(sb.size()), 32'h0);
    chk("t6_final_empty", {31'b0, bus.out_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
